// File: rtl/c1126_pkg.sv
// Shared types and symbol constants for the c1126 symbol interface.
package c1126_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_PRE  = 2'b11;
    localparam logic [1:0] SYM_STOP = 2'b00;

endpackage

// File: rtl/c1126_sym_tx.sv
// Serialises a parallel word into preamble, LSB-pair-first data, parity and stop
// symbols on the {tx1,tx0} lines, one symbol per clock.
module c1126_sym_tx #(
    parameter int DATA_W       = 8,
    parameter int PREAMBLE_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx0,
    output logic              tx1,
    output logic              busy_o,
    output logic              done_o
);
    import c1126_pkg::*;

    localparam int SYM_N   = DATA_W / 2;
    localparam int CNT_MAX = (PREAMBLE_LEN > SYM_N) ? PREAMBLE_LEN : SYM_N;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SYM_N - 1);

    // tx0 carries parity of even-index bits, tx1 parity of odd-index bits.
    function automatic logic [1:0] calc_parity(input logic [DATA_W-1:0] d);
        logic pe;
        logic po;
        pe = 1'b0;
        po = 1'b0;
        for (int i = 0; i < DATA_W; i += 2) begin
            pe ^= d[i];
            po ^= d[i+1];
        end
        return {po, pe};
    endfunction

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [1:0]        par_q, par_d;
    logic [1:0]        sym;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    // Counter restarts at zero on every state change so each state counts its own symbols.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shreg_d = data_i;
                    par_d   = calc_parity(data_i);
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                shreg_d = shreg_q >> 2;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = PAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                cnt_d   = '0;
                state_d = STOP;
            end
            STOP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sym     = SYM_IDLE;
        ready_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
            end
            PRE:  sym = SYM_PRE;
            DATA: sym = shreg_q[1:0];
            PAR:  sym = par_q;
            STOP: begin
                sym    = SYM_STOP;
                done_o = 1'b1;
            end
            default: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
            end
        endcase
    end

    assign tx0 = sym[0];
    assign tx1 = sym[1];

endmodule

// File: tb/tb_c1126_sym_tx.sv
// Randomised and directed bench for c1126_sym_tx at default and minimum parameters.
module tb_c1126_sym_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_a;
    logic       valid_a;
    logic       tx0_a, tx1_a, busy_a, done_a, ready_a;
    logic [1:0] data_b;
    logic       valid_b;
    logic       tx0_b, tx1_b, busy_b, done_b, ready_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [1:0] exp_q[$];

    c1126_sym_tx #(.DATA_W(8), .PREAMBLE_LEN(2)) dut_a (
        .clk(clk), .rst(rst), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
        .tx0(tx0_a), .tx1(tx1_a), .busy_o(busy_a), .done_o(done_a)
    );

    c1126_sym_tx #(.DATA_W(2), .PREAMBLE_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
        .tx0(tx0_b), .tx1(tx1_b), .busy_o(busy_b), .done_o(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: preamble of 11s, data pairs LSB first, split parity, stop.
    function automatic void build_frame(input logic [7:0] d, input int dw, input int pl);
        logic pe;
        logic po;
        exp_q.delete();
        pe = 1'b0;
        po = 1'b0;
        for (int i = 0; i < pl; i++) exp_q.push_back(2'b11);
        for (int k = 0; k < dw / 2; k++) exp_q.push_back(2'((d >> (2 * k)) & 8'h3));
        for (int b = 0; b < dw; b++) begin
            if (b % 2 == 0) pe = pe ^ d[b];
            else            po = po ^ d[b];
        end
        exp_q.push_back({po, pe});
        exp_q.push_back(2'b00);
    endfunction

    function automatic logic [1:0] get_sym(input int sel);
        return (sel != 0) ? {tx1_b, tx0_b} : {tx1_a, tx0_a};
    endfunction

    task automatic idle_chk(input int sel, input string tag);
        chk({tag, "_sym"},   32'(get_sym(sel)), 32'd0);
        chk({tag, "_busy"},  32'((sel != 0) ? busy_b : busy_a), 32'd0);
        chk({tag, "_done"},  32'((sel != 0) ? done_b : done_a), 32'd0);
        chk({tag, "_ready"}, 32'((sel != 0) ? ready_b : ready_a), 32'd1);
    endtask

    // Called at a falling edge with the DUT idle; returns at the STOP-cycle falling edge
    // (or one cycle after an abort reset, with rst released).
    task automatic run_frame(input int sel, input logic [7:0] d, input bit hold,
                             input int abort_at, output int hs_cyc);
        int dw;
        int pl;
        int len;
        dw = (sel != 0) ? 2 : 8;
        pl = (sel != 0) ? 1 : 2;
        build_frame(d, dw, pl);
        len = exp_q.size();
        idle_chk(sel, "pre_hs");
        hs_cyc = cyc;
        if (sel != 0) begin data_b = d[1:0]; valid_b = 1'b1; end
        else          begin data_a = d;      valid_a = 1'b1; end
        @(negedge clk);
        if (!hold) begin valid_a = 1'b0; valid_b = 1'b0; end
        data_a = 8'($urandom);
        data_b = 2'($urandom);
        for (int i = 0; i < len; i++) begin
            chk("sym",   32'(get_sym(sel)), 32'(exp_q[i]));
            chk("done",  32'((sel != 0) ? done_b : done_a), 32'(i == len - 1));
            chk("busy",  32'((sel != 0) ? busy_b : busy_a), 32'd1);
            chk("ready", 32'((sel != 0) ? ready_b : ready_a), 32'd0);
            if (i == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                idle_chk(sel, "abort");
                rst = 1'b1;
                return;
            end
            if (i != len - 1) @(negedge clk);
        end
    endtask

    initial begin
        int h1;
        int h2;
        valid_a = 1'b1;
        data_a  = 8'($urandom);
        valid_b = 1'b0;
        data_b  = 2'b00;

        repeat (3) begin
            @(negedge clk);
            idle_chk(0, "rst_a");
            idle_chk(1, "rst_b");
        end
        rst = 1'b1;
        run_frame(0, 8'($urandom), 1'b0, -1, h1);

        @(negedge clk);
        run_frame(0, 8'hB4, 1'b0, -1, h1);
        @(negedge clk);
        run_frame(0, 8'h01, 1'b0, -1, h1);

        @(negedge clk);
        run_frame(0, 8'hFF, 1'b1, -1, h1);
        @(negedge clk);
        run_frame(0, 8'h00, 1'b0, -1, h2);
        chk("b2b_period", 32'(h2 - h1), 32'd9);

        @(negedge clk);
        run_frame(0, 8'hB4, 1'b0, 3, h1);
        run_frame(0, 8'($urandom), 1'b0, -1, h1);

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 2)) begin
                idle_chk(0, "gap");
                @(negedge clk);
            end
            run_frame(0, 8'($urandom), 1'b0, -1, h1);
        end

        @(negedge clk);
        run_frame(1, 8'h02, 1'b0, -1, h1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            run_frame(1, 8'($urandom), 1'b0, -1, h1);
        end

        @(negedge clk);
        idle_chk(0, "end_a");
        idle_chk(1, "end_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
